l1_cache_control: RTL

Control FSM for the 2-way set-associative L1 cache. Sequences the cache datapath's tag/valid/dirty/LRU updates, data-array writes and write-back/allocate traffic to physical memory. Handshakes with the CPU-side requester (mem_read/mem_write/mem_resp) and the physical-memory side (pmem_read/pmem_write/pmem_resp). Also keeps hit/miss/write-back performance counters.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_perf_counter.sv | 27 ++
 rtl/l1_cache_control.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types for the L1 cache controller.
// State encoding, write-select codes and way decode.
package cache_pkg;

  localparam logic [1:0] WSEL_NONE = 2'b00;
  localparam logic [1:0] WSEL_PMEM = 2'b01;
  localparam logic [1:0] WSEL_CPU  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_WRITEBACK,
    S_ALLOCATE
  } state_e;

  function automatic logic [1:0] way_onehot(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cache_perf_counter.sv
// Wrapping event counter for cache statistics.
// Clears on synchronous reset, bumps on inc.
module cache_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/l1_cache_control.sv
// Control FSM for the 2-way set-associative L1 cache.
// Drives datapath strobes and pmem write-back/fill handshakes.
module l1_cache_control
  import cache_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic [1:0]       cache_hit,
  input  logic             way,
  input  logic             write_back,
  input  logic             way_reg,
  output logic             load_way_reg,
  output logic             way_sel,
  output logic [1:0]       write_sel,
  output logic [1:0]       read_data_array,
  output logic [1:0]       load_tag,
  output logic [1:0]       load_valid,
  output logic [1:0]       load_dirty,
  output logic             set_valid,
  output logic             set_dirty,
  output logic             load_lru,
  output logic             set_lru,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  state_e state_q, state_d;
  logic   from_alloc_q, from_alloc_d;
  logic   hit_inc, miss_inc, wb_inc;
  logic   hit;

  assign hit = |cache_hit;

  always_comb begin
    state_d         = state_q;
    from_alloc_d    = 1'b0;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    load_way_reg    = 1'b0;
    way_sel         = 1'b0;
    write_sel       = WSEL_NONE;
    read_data_array = 2'b00;
    load_tag        = 2'b00;
    load_valid      = 2'b00;
    load_dirty      = 2'b00;
    set_valid       = 1'b0;
    set_dirty       = 1'b0;
    load_lru        = 1'b0;
    set_lru         = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    wb_inc          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        read_data_array = 2'b11;
        if (mem_read || mem_write) state_d = S_CHECK;
      end
      S_CHECK: begin
        read_data_array = 2'b11;
        if (hit) begin
          mem_resp = 1'b1;
          load_lru = 1'b1;
          set_lru  = ~way;
          if (mem_write) begin
            way_sel    = way;
            write_sel  = WSEL_CPU;
            load_dirty = way_onehot(way);
            set_dirty  = 1'b1;
          end
          // the post-fill lookup is the tail of a miss, not a new hit
          hit_inc = ~from_alloc_q;
          state_d = S_IDLE;
        end else begin
          load_way_reg = 1'b1;
          miss_inc     = 1'b1;
          state_d      = write_back ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        way_sel    = way_reg;
        pmem_write = 1'b1;
        if (pmem_resp) begin
          wb_inc  = 1'b1;
          state_d = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        way_sel   = way_reg;
        pmem_read = 1'b1;
        if (pmem_resp) begin
          write_sel    = WSEL_PMEM;
          load_tag     = way_onehot(way_reg);
          load_valid   = way_onehot(way_reg);
          load_dirty   = way_onehot(way_reg);
          set_valid    = 1'b1;
          from_alloc_d = 1'b1;
          state_d      = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      from_alloc_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      from_alloc_q <= from_alloc_d;
    end
  end

  cache_perf_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  cache_perf_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

  cache_perf_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule
